commit_retire_queue: RTL and testbench

//  In-order retire buffer that feeds the commit stage: producer side of the commit_instr/commit_ack interface.

---
 rtl/commit_retire_queue_pkg.sv | 23 ++
 rtl/commit_retire_queue.sv | 154 +++++++++++++++
 tb/tb_commit_retire_queue.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_retire_queue_pkg.sv
// Shared types for the retire queue: exception record, scoreboard entry and widths.
package commit_retire_queue_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [4:0]               rd;
    logic [XLEN-1:0]          result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;

endpackage

// File: rtl/commit_retire_queue.sv
// In-order retire buffer: tags issued instructions, collects writebacks and
// presents the oldest completed entries to commit, freeing them on acknowledge.
module commit_retire_queue
  import commit_retire_queue_pkg::*;
#(
  parameter int NR_ENTRIES      = 8,
  parameter int NR_COMMIT_PORTS = 2,
  parameter int NR_WB_PORTS     = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  scoreboard_entry_t                           issue_instr_i,
  input  logic                                        issue_valid_i,
  output logic                                        issue_ack_o,
  output logic [TRANS_ID_BITS-1:0]                    issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]                wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]     commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]                  commit_ack_i,
  output logic [$clog2(NR_ENTRIES):0]                 count_o
);

  localparam int IDX   = $clog2(NR_ENTRIES);
  localparam int CNT_W = IDX + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NR_ENTRIES);

  scoreboard_entry_t mem_q [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]      occ_q, occ_d, done_q, done_d;
  logic [IDX-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d, pops;
  logic [NR_COMMIT_PORTS-1:0] commit_valid, pop_en;
  logic                       push;

  // Fullness uses the registered count, so a same-cycle pop never frees a slot for this push.
  assign push             = issue_valid_i & (count_q < CNT_FULL) & ~flush_i;
  assign issue_ack_o      = push;
  assign issue_trans_id_o = tail_q;
  assign count_o          = count_q;

  always_comb begin
    commit_instr_o = '0;
    commit_valid   = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      commit_instr_o[i]       = mem_q[head_q + IDX'(i)];
      commit_valid[i]         = occ_q[head_q + IDX'(i)] & done_q[head_q + IDX'(i)] &
                                (CNT_W'(i) < count_q);
      commit_instr_o[i].valid = commit_valid[i];
    end
  end

  always_comb begin
    pop_en    = '0;
    pop_en[0] = commit_ack_i[0] & commit_valid[0];
    for (int i = 1; i < NR_COMMIT_PORTS; i++) begin
      pop_en[i] = pop_en[i-1] & commit_ack_i[i] & commit_valid[i];
    end
    pops = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      pops = pops + CNT_W'(pop_en[i]);
    end
  end

  always_comb begin
    occ_d  = occ_q;
    done_d = done_q;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_valid_i[p] && occ_q[wb_trans_id_i[p]]) begin
        done_d[wb_trans_id_i[p]] = 1'b1;
      end
    end
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (pop_en[i]) begin
        occ_d[head_q + IDX'(i)]  = 1'b0;
        done_d[head_q + IDX'(i)] = 1'b0;
      end
    end
    if (push) begin
      occ_d[tail_q]  = 1'b1;
      done_d[tail_q] = 1'b0;
    end
    head_d  = head_q + pops[IDX-1:0];
    tail_d  = tail_q + IDX'(push);
    count_d = count_q + CNT_W'(push) - pops;
    if (flush_i) begin
      occ_d   = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q   <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is not reset; visibility is governed solely by occ/done. Ports are
  // walked high-to-low so the lowest-index writer to an entry lands last.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && occ_q[wb_trans_id_i[p]]) begin
          mem_q[wb_trans_id_i[p]].result <= wb_result_i[p];
          if (wb_ex_i[p].valid) begin
            mem_q[wb_trans_id_i[p]].ex <= wb_ex_i[p];
          end
        end
      end
      if (push) begin
        mem_q[tail_q]          <= issue_instr_i;
        mem_q[tail_q].trans_id <= tail_q;
        mem_q[tail_q].ex.valid <= 1'b0;
      end
    end
  end

  if (NR_ENTRIES < 2 || (NR_ENTRIES & (NR_ENTRIES - 1)) != 0 ||
      NR_ENTRIES != (1 << TRANS_ID_BITS) ||
      NR_COMMIT_PORTS < 1 || NR_COMMIT_PORTS > 2) begin : g_bad_cfg
    $error("commit_retire_queue: unsupported parameter set");
  end

  for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_ack_chk
    a_ack_valid : assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
      commit_ack_i[i] |-> commit_valid[i]);
    if (i > 0) begin : g_prefix
      a_ack_prefix : assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        commit_ack_i[i] |-> commit_ack_i[i-1]);
    end
  end

  for (genvar a = 0; a < NR_WB_PORTS; a++) begin : g_wb_a
    for (genvar b = a + 1; b < NR_WB_PORTS; b++) begin : g_wb_b
      a_wb_unique : assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        !(wb_valid_i[a] && wb_valid_i[b] && wb_trans_id_i[a] == wb_trans_id_i[b]));
    end
  end

endmodule

// File: tb/tb_commit_retire_queue.sv
// Directed scenarios plus randomized traffic checked against a queue-based model of retire order.
module tb_commit_retire_queue;
  import commit_retire_queue_pkg::*;

  localparam int NE = 8;
  localparam int NC = 2;
  localparam int NW = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;
  scoreboard_entry_t issue_instr_i = '0;
  logic issue_valid_i = 1'b0;
  logic issue_ack_o;
  logic [TRANS_ID_BITS-1:0] issue_trans_id_o;
  logic [NW-1:0] wb_valid_i = '0;
  logic [NW-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i = '0;
  logic [NW-1:0][XLEN-1:0] wb_result_i = '0;
  exception_t [NW-1:0] wb_ex_i = '0;
  scoreboard_entry_t [NC-1:0] commit_instr_o;
  logic [NC-1:0] commit_ack_i = '0;
  logic [3:0] count_o;

  commit_retire_queue #(.NR_ENTRIES(NE), .NR_COMMIT_PORTS(NC), .NR_WB_PORTS(NW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_instr_i(issue_instr_i), .issue_valid_i(issue_valid_i),
    .issue_ack_o(issue_ack_o), .issue_trans_id_o(issue_trans_id_o),
    .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
    .wb_result_i(wb_result_i), .wb_ex_i(wb_ex_i),
    .commit_instr_o(commit_instr_o), .commit_ack_i(commit_ack_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] result;
    bit          exv;
    logic [31:0] cause;
    logic [31:0] tval;
  } mrec_t;

  mrec_t mq[$];
  int next_id = 0;
  int checks = 0;
  int errors = 0;

  // Full comparison of the visible interface against the model, before the edge.
  task automatic compare_to_model(input string tag);
    bit exp_ack;
    bit exp_v;
    exp_ack = issue_valid_i && (mq.size() < NE) && !flush_i;
    checks++;
    if (issue_ack_o !== exp_ack) begin
      errors++; $display("FAIL %s issue_ack got %0b exp %0b", tag, issue_ack_o, exp_ack);
    end
    checks++;
    if (issue_trans_id_o !== 3'(next_id)) begin
      errors++; $display("FAIL %s trans_id got %0d exp %0d", tag, issue_trans_id_o, next_id);
    end
    checks++;
    if (count_o !== 4'(mq.size())) begin
      errors++; $display("FAIL %s count got %0d exp %0d", tag, count_o, mq.size());
    end
    for (int i = 0; i < NC; i++) begin
      exp_v = (i < mq.size()) && mq[i].done;
      checks++;
      if (commit_instr_o[i].valid !== exp_v) begin
        errors++; $display("FAIL %s port%0d valid got %0b exp %0b", tag, i, commit_instr_o[i].valid, exp_v);
      end else if (exp_v) begin
        checks++;
        if (commit_instr_o[i].trans_id !== 3'(mq[i].id) || commit_instr_o[i].pc !== mq[i].pc ||
            commit_instr_o[i].rd !== mq[i].rd || commit_instr_o[i].result !== mq[i].result ||
            commit_instr_o[i].ex.valid !== mq[i].exv ||
            (mq[i].exv && (commit_instr_o[i].ex.cause !== mq[i].cause ||
                           commit_instr_o[i].ex.tval !== mq[i].tval))) begin
          errors++;
          $display("FAIL %s port%0d entry got id=%0d pc=%h res=%h exv=%0b cause=%0d exp id=%0d pc=%h res=%h exv=%0b cause=%0d",
                   tag, i, commit_instr_o[i].trans_id, commit_instr_o[i].pc, commit_instr_o[i].result,
                   commit_instr_o[i].ex.valid, commit_instr_o[i].ex.cause,
                   mq[i].id, mq[i].pc, mq[i].result, mq[i].exv, mq[i].cause);
        end
      end
    end
  endtask

  task automatic model_update();
    int  npop;
    bit  do_push;
    bit  seen [NE];
    if (flush_i) begin
      mq.delete();
      next_id = 0;
      return;
    end
    do_push = issue_valid_i && (mq.size() < NE);
    npop = 0;
    for (int i = 0; i < NC; i++) begin
      if (commit_ack_i[i] && i < mq.size() && mq[i].done && npop == i) npop++;
    end
    foreach (seen[k]) seen[k] = 1'b0;
    for (int p = 0; p < NW; p++) begin
      if (wb_valid_i[p] && !seen[wb_trans_id_i[p]]) begin
        seen[wb_trans_id_i[p]] = 1'b1;
        for (int k = 0; k < mq.size(); k++) begin
          if (mq[k].id == int'(wb_trans_id_i[p])) begin
            mq[k].done = 1'b1;
            mq[k].result = wb_result_i[p];
            if (wb_ex_i[p].valid) begin
              mq[k].exv = 1'b1;
              mq[k].cause = wb_ex_i[p].cause;
              mq[k].tval = wb_ex_i[p].tval;
            end
          end
        end
      end
    end
    repeat (npop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back('{id: next_id, pc: issue_instr_i.pc, rd: issue_instr_i.rd, done: 1'b0,
                     result: issue_instr_i.result, exv: 1'b0,
                     cause: issue_instr_i.ex.cause, tval: issue_instr_i.ex.tval});
      next_id = (next_id + 1) % NE;
    end
  endtask

  task automatic tick(input string tag);
    #1;
    compare_to_model(tag);
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic idle();
    issue_valid_i = 1'b0;
    wb_valid_i = '0;
    commit_ack_i = '0;
    flush_i = 1'b0;
  endtask

  task automatic set_push();
    issue_valid_i = 1'b1;
    issue_instr_i.pc = $urandom();
    issue_instr_i.rd = 5'($urandom());
    issue_instr_i.fu = 4'($urandom());
    issue_instr_i.result = $urandom();
    issue_instr_i.trans_id = 3'($urandom());
    issue_instr_i.valid = 1'($urandom());
    issue_instr_i.ex.valid = 1'b1;
    issue_instr_i.ex.cause = $urandom();
    issue_instr_i.ex.tval = $urandom();
  endtask

  task automatic set_wb(input int p, input int id, input logic [31:0] res,
                        input bit exv, input logic [31:0] cause);
    wb_valid_i[p] = 1'b1;
    wb_trans_id_i[p] = 3'(id);
    wb_result_i[p] = res;
    wb_ex_i[p].valid = exv;
    wb_ex_i[p].cause = cause;
    wb_ex_i[p].tval = $urandom();
  endtask

  task automatic do_flush();
    idle(); flush_i = 1'b1; tick("flush"); idle();
  endtask

  task automatic push_n(input int n);
    for (int k = 0; k < n; k++) begin
      idle(); set_push(); tick("push");
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    @(negedge clk_i);
    #1;
    checks++;
    if (count_o !== 4'd0 || issue_ack_o !== 1'b0 || commit_instr_o[0].valid !== 1'b0 ||
        commit_instr_o[1].valid !== 1'b0 || issue_trans_id_o !== 3'd0) begin
      errors++; $display("FAIL reset state count=%0d ack=%0b v0=%0b v1=%0b id=%0d exp all zero",
                         count_o, issue_ack_o, commit_instr_o[0].valid, commit_instr_o[1].valid, issue_trans_id_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_in_order();
    do_flush();
    push_n(3);
    set_wb(0, 1, 32'h1111_0001, 1'b0, 0); tick("wb1"); idle();
    checks++;
    if (commit_instr_o[0].valid !== 1'b0 || commit_instr_o[1].valid !== 1'b1 || commit_instr_o[1].trans_id !== 3'd1) begin
      errors++; $display("FAIL in_order after wb1 v0=%0b v1=%0b id1=%0d exp 0 1 1",
                         commit_instr_o[0].valid, commit_instr_o[1].valid, commit_instr_o[1].trans_id);
    end
    set_wb(2, 0, 32'h1111_0000, 1'b0, 0); tick("wb0"); idle();
    checks++;
    if (commit_instr_o[0].valid !== 1'b1 || commit_instr_o[0].trans_id !== 3'd0 || commit_instr_o[1].valid !== 1'b1) begin
      errors++; $display("FAIL in_order after wb0 v0=%0b id0=%0d v1=%0b exp 1 0 1",
                         commit_instr_o[0].valid, commit_instr_o[0].trans_id, commit_instr_o[1].valid);
    end
    commit_ack_i = 2'b11; tick("ack2"); idle();
    checks++;
    if (count_o !== 4'd1 || commit_instr_o[0].trans_id !== 3'd2 || commit_instr_o[0].valid !== 1'b0) begin
      errors++; $display("FAIL in_order after ack count=%0d id0=%0d v0=%0b exp 1 2 0",
                         count_o, commit_instr_o[0].trans_id, commit_instr_o[0].valid);
    end
    set_wb(1, 2, $urandom(), 1'b0, 0); tick("wb2"); idle();
    commit_ack_i = 2'b01; tick("ack1"); idle();
  endtask

  task automatic test_full();
    do_flush();
    push_n(NE);
    set_push(); #1;
    checks++;
    if (issue_ack_o !== 1'b0 || count_o !== 4'd8) begin
      errors++; $display("FAIL full ninth push ack=%0b count=%0d exp 0 8", issue_ack_o, count_o);
    end
    tick("ninth"); idle();
    set_wb(0, 0, $urandom(), 1'b0, 0); tick("wbhead"); idle();
    commit_ack_i = 2'b01; set_push(); #1;
    checks++;
    if (issue_ack_o !== 1'b0) begin
      errors++; $display("FAIL full push_with_pop ack=%0b exp 0", issue_ack_o);
    end
    tick("pop_push"); idle();
    checks++;
    if (count_o !== 4'd7) begin
      errors++; $display("FAIL full count_after_pop got %0d exp 7", count_o);
    end
  endtask

  task automatic test_wrap();
    do_flush();
    for (int k = 0; k < 10; k++) begin
      idle(); set_push(); #1;
      checks++;
      if (issue_trans_id_o !== 3'(k % NE)) begin
        errors++; $display("FAIL wrap id got %0d exp %0d", issue_trans_id_o, k % NE);
      end
      tick("wrap_push"); idle();
      set_wb(k % NW, k % NE, $urandom(), 1'b0, 0); tick("wrap_wb"); idle();
      commit_ack_i = 2'b01; #1;
      checks++;
      if (commit_instr_o[0].valid !== 1'b1 || commit_instr_o[0].trans_id !== 3'(k % NE)) begin
        errors++; $display("FAIL wrap commit v=%0b id=%0d exp 1 %0d",
                           commit_instr_o[0].valid, commit_instr_o[0].trans_id, k % NE);
      end
      tick("wrap_ack");
    end
    idle();
  endtask

  task automatic test_exception();
    do_flush();
    push_n(4);
    set_wb(0, 0, $urandom(), 1'b0, 0);
    set_wb(1, 1, $urandom(), 1'b0, 0);
    set_wb(2, 2, $urandom(), 1'b0, 0);
    set_wb(3, 3, 32'hCAFE_0003, 1'b1, 32'd2);
    tick("ex_wb"); idle();
    commit_ack_i = 2'b11; tick("ex_ack2"); idle();
    commit_ack_i = 2'b01; tick("ex_ack1"); idle();
    checks++;
    if (commit_instr_o[0].valid !== 1'b1 || commit_instr_o[0].trans_id !== 3'd3 ||
        commit_instr_o[0].ex.valid !== 1'b1 || commit_instr_o[0].ex.cause !== 32'd2 ||
        commit_instr_o[0].result !== 32'hCAFE_0003) begin
      errors++; $display("FAIL exception v=%0b id=%0d exv=%0b cause=%0d res=%h exp 1 3 1 2 cafe0003",
                         commit_instr_o[0].valid, commit_instr_o[0].trans_id, commit_instr_o[0].ex.valid,
                         commit_instr_o[0].ex.cause, commit_instr_o[0].result);
    end
    commit_ack_i = 2'b01; tick("ex_retire"); idle();
  endtask

  task automatic test_flush();
    do_flush();
    push_n(5);
    set_wb(0, 0, $urandom(), 1'b0, 0); tick("fl_wb"); idle();
    flush_i = 1'b1; set_push(); commit_ack_i = 2'b01;
    set_wb(1, 1, $urandom(), 1'b0, 0); #1;
    checks++;
    if (issue_ack_o !== 1'b0) begin
      errors++; $display("FAIL flush push_ack got %0b exp 0", issue_ack_o);
    end
    tick("fl_cycle"); idle();
    checks++;
    if (count_o !== 4'd0 || commit_instr_o[0].valid !== 1'b0 || commit_instr_o[1].valid !== 1'b0 ||
        issue_trans_id_o !== 3'd0) begin
      errors++; $display("FAIL flush after count=%0d v0=%0b v1=%0b id=%0d exp 0 0 0 0",
                         count_o, commit_instr_o[0].valid, commit_instr_o[1].valid, issue_trans_id_o);
    end
    push_n(1);
    checks++;
    if (count_o !== 4'd1 || commit_instr_o[0].trans_id !== 3'd0) begin
      errors++; $display("FAIL flush repush count=%0d id=%0d exp 1 0", count_o, commit_instr_o[0].trans_id);
    end
  endtask

  task automatic test_stale_wb();
    do_flush();
    push_n(5);
    set_wb(0, 5, 32'hDEAD_0005, 1'b0, 0); tick("stale_wb"); idle();
    push_n(1);
    for (int p = 0; p < 4; p++) set_wb(p, p, $urandom(), 1'b0, 0);
    tick("st_wb03"); idle();
    commit_ack_i = 2'b11; tick("st_ack01"); idle();
    commit_ack_i = 2'b11; set_wb(0, 4, $urandom(), 1'b0, 0); tick("st_ack23"); idle();
    commit_ack_i = 2'b01; tick("st_ack4"); idle();
    checks++;
    if (commit_instr_o[0].valid !== 1'b0 || commit_instr_o[0].trans_id !== 3'd5 || count_o !== 4'd1) begin
      errors++; $display("FAIL stale_wb v=%0b id=%0d count=%0d exp 0 5 1",
                         commit_instr_o[0].valid, commit_instr_o[0].trans_id, count_o);
    end
  endtask

  task automatic test_random();
    int perm [NE];
    int j, t;
    bit a0;
    do_flush();
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(9) < 7) set_push();
      for (int k = 0; k < NE; k++) perm[k] = k;
      for (int k = NE - 1; k > 0; k--) begin
        j = $urandom_range(k); t = perm[k]; perm[k] = perm[j]; perm[j] = t;
      end
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(1) == 1)
          set_wb(p, perm[p], $urandom(), ($urandom_range(7) == 0), $urandom_range(15));
      end
      a0 = (mq.size() > 0) && mq[0].done && ($urandom_range(3) != 0);
      commit_ack_i[0] = a0;
      commit_ack_i[1] = a0 && (mq.size() > 1) && mq[1].done && ($urandom_range(1) == 1);
      flush_i = ($urandom_range(49) == 0);
      tick("random");
    end
    idle();
  endtask

  task automatic test_reset_mid();
    push_n(3);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (count_o !== 4'd0 || commit_instr_o[0].valid !== 1'b0 || issue_trans_id_o !== 3'd0 || issue_ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid count=%0d v0=%0b id=%0d ack=%0b exp 0 0 0 0",
                         count_o, commit_instr_o[0].valid, issue_trans_id_o, issue_ack_o);
    end
    mq.delete();
    next_id = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    push_n(2);
    tick("post_reset");
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_wrap();
    test_exception();
    test_flush();
    test_stale_wb();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
